// File: rtl/seq_pkg.sv
// Shared types and encodings for the datapath sequencer: FSM states,
// instruction opcode/op constants and datapath select encodings.
package seq_pkg;
  typedef enum logic [2:0] {
    WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_RD, WRITE_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] CMP = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] MVN = 2'b11;

  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_NONE = 3'b000;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;
endpackage

// File: rtl/datapath_sequencer_insn_decoder.sv
// Combinational instruction decode: IR fields, sign-extended immediates,
// the state that follows DECODE, and instruction class flags.
module insn_decoder
  import seq_pkg::*;
#(
  parameter int INSN_W = 16
) (
  input  logic [INSN_W-1:0] i_ir,
  output logic [1:0]        o_op,
  output logic [1:0]        o_shift,
  output logic [INSN_W-1:0] o_sximm5,
  output logic [INSN_W-1:0] o_sximm8,
  output state_t            o_next,
  output logic              o_movreg,
  output logic              o_cmp,
  output logic              o_illegal
);
  logic [2:0] w_opc;
  // Rn/Rd/Rm indices are muxed in the datapath; only nsel is driven here.
  logic [8:0] w_unused_regs;

  assign w_opc         = i_ir[15:13];
  assign o_op          = i_ir[12:11];
  assign o_shift       = i_ir[4:3];
  assign w_unused_regs = {i_ir[10:8], i_ir[7:5], i_ir[2:0]};
  assign o_sximm8      = {{(INSN_W-8){i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5      = {{(INSN_W-5){i_ir[4]}}, i_ir[4:0]};
  assign o_movreg      = (w_opc == OPC_MOV) && (o_op == OP_MOV_REG);
  assign o_cmp         = (w_opc == OPC_ALU) && (o_op == CMP);

  always_comb begin
    o_next    = WAIT;
    o_illegal = 1'b1;
    if (w_opc == OPC_MOV && o_op == OP_MOV_IMM) begin
      o_next    = WRITE_IMM;
      o_illegal = 1'b0;
    end else if (o_movreg) begin
      o_next    = GET_B;
      o_illegal = 1'b0;
    end else if (w_opc == OPC_ALU) begin
      o_next    = (o_op == MVN) ? GET_B : GET_A;
      o_illegal = 1'b0;
    end
  end
endmodule

// File: rtl/datapath_sequencer.sv
// Moore FSM that steps the register-file/ALU datapath through one
// instruction per start handshake; outputs depend only on state and IR.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int INSN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [INSN_W-1:0] in,
  output logic              w,
  output logic              illegal,
  output logic [2:0]        nsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic              write,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift,
  output logic [INSN_W-1:0] sximm8,
  output logic [INSN_W-1:0] sximm5
);
  state_t            r_state, w_next;
  logic [INSN_W-1:0] r_ir;
  logic [1:0]        w_op, w_shift, w_alu;
  state_t            w_dec_next;
  logic              w_movreg, w_cmp, w_illegal;

  insn_decoder #(.INSN_W(INSN_W)) u_dec (
    .i_ir      (r_ir),
    .o_op      (w_op),
    .o_shift   (w_shift),
    .o_sximm5  (sximm5),
    .o_sximm8  (sximm8),
    .o_next    (w_dec_next),
    .o_movreg  (w_movreg),
    .o_cmp     (w_cmp),
    .o_illegal (w_illegal)
  );

  // MOV reg reuses the ALU as a pass-through: 0 + shifted B.
  assign w_alu = w_movreg ? ADD : w_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT && s) r_ir <= in;
    end
  end

  always_comb begin
    w_next  = r_state;
    w       = 1'b0;
    illegal = 1'b0;
    nsel    = NSEL_NONE;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    vsel    = VSEL_C;
    write   = 1'b0;
    alu_op  = ADD;
    shift   = 2'b00;
    case (r_state)
      WAIT: begin
        w = 1'b1;
        if (s) w_next = DECODE;
      end
      DECODE: begin
        illegal = w_illegal;
        w_next  = w_dec_next;
      end
      GET_A: begin
        nsel   = NSEL_RN;
        loada  = 1'b1;
        alu_op = w_alu;
        w_next = GET_B;
      end
      GET_B: begin
        nsel   = NSEL_RM;
        loadb  = 1'b1;
        alu_op = w_alu;
        shift  = w_shift;
        w_next = EXEC;
      end
      EXEC: begin
        loadc  = 1'b1;
        asel   = w_movreg;
        alu_op = w_alu;
        shift  = w_shift;
        loads  = w_cmp;
        w_next = w_cmp ? WAIT : WRITE_RD;
      end
      WRITE_RD: begin
        nsel   = NSEL_RD;
        vsel   = VSEL_C;
        write  = 1'b1;
        w_next = WAIT;
      end
      WRITE_IMM: begin
        nsel   = NSEL_RN;
        vsel   = VSEL_IMM8;
        write  = 1'b1;
        w_next = WAIT;
      end
      default: w_next = WAIT;
    endcase
  end
endmodule

// File: tb/tb_datapath_sequencer.sv
// Table-driven bench: per-instruction expected output traces are queued on
// issue and popped against the DUT one cycle at a time.
module tb_datapath_sequencer;
  typedef struct packed {
    logic       w, ill;
    logic [2:0] nsel;
    logic       la, lb, lc, ls, asel, bsel;
    logic [1:0] vsel;
    logic       wr;
    logic [1:0] alu, sh;
  } outs_t;

  typedef struct packed {
    logic [15:0] insn;
    logic [2:0]  cyc;
    outs_t       exp;
    logic [15:0] imm8;
  } vec_t;

  localparam logic [2:0] NO = 3'b000, RN = 3'b100, RD = 3'b010, RM = 3'b001;

  logic        clk, reset_n, s;
  logic [15:0] tb_in;
  logic        w, illegal, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0]  nsel;
  logic [1:0]  vsel, alu_op, shift;
  logic [15:0] sximm8, sximm5;

  int    checks = 0, passes = 0;
  vec_t  tbl[$];
  vec_t  sb[$];
  outs_t Z, W;

  datapath_sequencer #(.INSN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(tb_in),
    .w(w), .illegal(illegal), .nsel(nsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .alu_op(alu_op), .shift(shift), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic w_, ill, input logic [2:0] ns,
                               input logic la, lb, lc, ls, as,
                               input logic [1:0] vs, input logic wr,
                               input logic [1:0] alu, sh);
    outs_t o;
    o = {w_, ill, ns, la, lb, lc, ls, as, 1'b0, vs, wr, alu, sh};
    return o;
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o = {w, illegal, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, alu_op, shift};
    return o;
  endfunction

  task automatic add(input logic [15:0] insn, input logic [2:0] cyc, input outs_t e,
                     input logic [15:0] imm);
    vec_t v;
    v = '{insn, cyc, e, imm};
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input vec_t v);
    outs_t a;
    a = cur();
    checks++;
    if (a !== v.exp || sximm8 !== v.imm8)
      $display("FAIL %s insn=%h cyc=%0d got=%b/%h want=%b/%h",
               nm, v.insn, v.cyc, a, sximm8, v.exp, v.imm8);
    else passes++;
  endtask

  task automatic push_insn(input logic [15:0] insn);
    foreach (tbl[i]) if (tbl[i].insn == insn) sb.push_back(tbl[i]);
  endtask

  // Pops one expected row per cycle; s/in are scrambled mid-instruction.
  task automatic drain();
    int guard;
    vec_t v;
    guard = 0;
    while (sb.size() > 0 && guard < 16) begin
      @(posedge clk); @(negedge clk);
      v = sb.pop_front();
      check("trace", v);
      guard++;
      if (sb.size() > 0) begin
        s = 1'($urandom);
        tb_in = 16'($urandom);
      end else s = 1'b0;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout left=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_insn(input logic [15:0] insn);
    push_insn(insn);
    s = 1'b1;
    tb_in = insn;
    drain();
  endtask

  initial begin
    logic [15:0] order[6];
    vec_t v;
    order = '{16'hD007, 16'hD0F8, 16'hA140, 16'hA900, 16'hB86A, 16'hB158};
    Z = '0;
    W = mk(1,0,NO,0,0,0,0,0,2'b00,0,2'b00,2'b00);
    // MOV imm
    add(16'hD007,1,Z,16'h0007);
    add(16'hD007,2,mk(0,0,RN,0,0,0,0,0,2'b01,1,2'b00,2'b00),16'h0007);
    add(16'hD007,3,W,16'h0007);
    add(16'hD0F8,1,Z,16'hFFF8);
    add(16'hD0F8,2,mk(0,0,RN,0,0,0,0,0,2'b01,1,2'b00,2'b00),16'hFFF8);
    add(16'hD0F8,3,W,16'hFFF8);
    // ADD R2,R1,R0
    add(16'hA140,1,Z,16'h0040);
    add(16'hA140,2,mk(0,0,RN,1,0,0,0,0,2'b00,0,2'b00,2'b00),16'h0040);
    add(16'hA140,3,mk(0,0,RM,0,1,0,0,0,2'b00,0,2'b00,2'b00),16'h0040);
    add(16'hA140,4,mk(0,0,NO,0,0,1,0,0,2'b00,0,2'b00,2'b00),16'h0040);
    add(16'hA140,5,mk(0,0,RD,0,0,0,0,0,2'b00,1,2'b00,2'b00),16'h0040);
    add(16'hA140,6,W,16'h0040);
    // CMP R1,R0
    add(16'hA900,1,Z,16'h0000);
    add(16'hA900,2,mk(0,0,RN,1,0,0,0,0,2'b00,0,2'b01,2'b00),16'h0000);
    add(16'hA900,3,mk(0,0,RM,0,1,0,0,0,2'b00,0,2'b01,2'b00),16'h0000);
    add(16'hA900,4,mk(0,0,NO,0,0,1,1,0,2'b00,0,2'b01,2'b00),16'h0000);
    add(16'hA900,5,W,16'h0000);
    // MVN R3,R2,LSL#1
    add(16'hB86A,1,Z,16'h006A);
    add(16'hB86A,2,mk(0,0,RM,0,1,0,0,0,2'b00,0,2'b11,2'b01),16'h006A);
    add(16'hB86A,3,mk(0,0,NO,0,0,1,0,0,2'b00,0,2'b11,2'b01),16'h006A);
    add(16'hB86A,4,mk(0,0,RD,0,0,0,0,0,2'b00,1,2'b00,2'b00),16'h006A);
    add(16'hB86A,5,W,16'h006A);
    // AND R2,R1,R0 with shift field 11
    add(16'hB158,1,Z,16'h0058);
    add(16'hB158,2,mk(0,0,RN,1,0,0,0,0,2'b00,0,2'b10,2'b00),16'h0058);
    add(16'hB158,3,mk(0,0,RM,0,1,0,0,0,2'b00,0,2'b10,2'b11),16'h0058);
    add(16'hB158,4,mk(0,0,NO,0,0,1,0,0,2'b00,0,2'b10,2'b11),16'h0058);
    add(16'hB158,5,mk(0,0,RD,0,0,0,0,0,2'b00,1,2'b00,2'b00),16'h0058);
    add(16'hB158,6,W,16'h0058);
    // illegal, then MOV reg R0,R1 back-to-back
    add(16'hE000,1,mk(0,1,NO,0,0,0,0,0,2'b00,0,2'b00,2'b00),16'h0000);
    add(16'hE000,2,W,16'h0000);
    add(16'hC001,1,Z,16'h0001);
    add(16'hC001,2,mk(0,0,RM,0,1,0,0,0,2'b00,0,2'b00,2'b00),16'h0001);
    add(16'hC001,3,mk(0,0,NO,0,0,1,0,1,2'b00,0,2'b00,2'b00),16'h0001);
    add(16'hC001,4,mk(0,0,RD,0,0,0,0,0,2'b00,1,2'b00,2'b00),16'h0001);
    add(16'hC001,5,W,16'h0001);

    clk = 1'b0; reset_n = 1'b0; s = 1'b0; tb_in = '0;
    #3;
    v = '{16'h0000, 3'd0, W, 16'h0000};
    check("reset_state", v);
    @(negedge clk); reset_n = 1'b1;

    foreach (order[i]) begin
      run_insn(order[i]);
      if (order[i] == 16'hB86A) begin
        checks++;
        if (sximm5 !== 16'h000A) $display("FAIL sximm5_pos got=%h want=000A", sximm5);
        else passes++;
      end
      if (order[i] == 16'hB158) begin
        checks++;
        if (sximm5 !== 16'hFFF8) $display("FAIL sximm5_neg got=%h want=FFF8", sximm5);
        else passes++;
      end
    end

    // s held high: illegal returns to WAIT, next instruction taken immediately
    push_insn(16'hE000);
    s = 1'b1; tb_in = 16'hE000;
    @(posedge clk); @(negedge clk);
    v = sb.pop_front(); check("illegal", v);
    tb_in = 16'hC001;
    @(posedge clk); @(negedge clk);
    v = sb.pop_front(); check("illegal_wait", v);
    push_insn(16'hC001);
    drain();

    // async reset during GET_B of an ADD
    s = 1'b1; tb_in = 16'hA140;
    @(posedge clk); @(negedge clk); s = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    v = '{16'hA140, 3'd3, mk(0,0,RM,0,1,0,0,0,2'b00,0,2'b00,2'b00), 16'h0040};
    check("pre_reset_getb", v);
    #2 reset_n = 1'b0;
    #1;
    v = '{16'hA140, 3'd3, W, 16'h0000};
    check("async_reset", v);
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      v = '{16'h0000, 3'(k), W, 16'h0000};
      check("post_reset_idle", v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
